// File: rtl/nios2_mul_pipe.sv
// rtl/nios2_mul_pipe.sv - pipelined WIDTHxWIDTH multiplier, four half-width partial products, per-operand signedness
module nios2_mul_pipe #(
   parameter int WIDTH   = 32,
   parameter int REG_OUT = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   src1,
   input  logic [WIDTH-1:0]   src2,
   input  logic               src1_signed,
   input  logic               src2_signed,
   input  logic               hi_sel,
   output logic               out_valid,
   output logic [WIDTH-1:0]   result,
   output logic [2*WIDTH-1:0] prod
);

   localparam int H = WIDTH / 2;
   localparam int P = 2 * WIDTH;

   // stage 1: captured operands and their mode bits
   logic [WIDTH-1:0] a1, b1;
   logic             sa1, sb1, hi1, v1;

   // stage 2: partial products and sign corrections
   logic [WIDTH-1:0] ll2, lh2, hl2, hh2;
   logic [WIDTH-1:0] corr_a2, corr_b2;
   logic             hi2, v2;

   // stage 3: assembled product
   logic [P-1:0]     p3;
   logic [WIDTH-1:0] r3;
   logic             v3;

   // zero-extended half operands so every product is formed at full WIDTH
   logic [WIDTH-1:0] a_lo, a_hi, b_lo, b_hi;
   assign a_lo = {{H{1'b0}}, a1[H-1:0]};
   assign a_hi = {{H{1'b0}}, a1[WIDTH-1:H]};
   assign b_lo = {{H{1'b0}}, b1[H-1:0]};
   assign b_hi = {{H{1'b0}}, b1[WIDTH-1:H]};

   // stage 1 register: sample operands and mode bits when the pipe advances
   always_ff @(posedge clk) begin
      if (reset) begin
         a1  <= '0;
         b1  <= '0;
         sa1 <= 1'b0;
         sb1 <= 1'b0;
         hi1 <= 1'b0;
         v1  <= 1'b0;
      end else if (en) begin
         a1  <= src1;
         b1  <= src2;
         sa1 <= src1_signed;
         sb1 <= src2_signed;
         hi1 <= hi_sel;
         v1  <= in_valid;
      end
   end

   // stage 2 register: unsigned partial products plus the terms that turn them signed
   always_ff @(posedge clk) begin
      if (reset) begin
         ll2     <= '0;
         lh2     <= '0;
         hl2     <= '0;
         hh2     <= '0;
         corr_a2 <= '0;
         corr_b2 <= '0;
         hi2     <= 1'b0;
         v2      <= 1'b0;
      end else if (en) begin
         ll2     <= a_lo * b_lo;
         lh2     <= a_lo * b_hi;
         hl2     <= a_hi * b_lo;
         hh2     <= a_hi * b_hi;
         // a negative signed operand is worth 2^WIDTH less than its unsigned reading
         corr_a2 <= (a1[WIDTH-1] & sa1) ? b1 : '0;
         corr_b2 <= (b1[WIDTH-1] & sb1) ? a1 : '0;
         hi2     <= hi1;
         v2      <= v1;
      end
   end

   logic [P-1:0]     sum;
   logic [WIDTH-1:0] sel;

   // combine partial products modulo 2^(2*WIDTH); the sa&sb cross term vanishes at this width
   always_comb begin
      sum = {{WIDTH{1'b0}}, ll2}
          + ({{WIDTH{1'b0}}, lh2} << H)
          + ({{WIDTH{1'b0}}, hl2} << H)
          + {hh2, {WIDTH{1'b0}}}
          - {corr_a2, {WIDTH{1'b0}}}
          - {corr_b2, {WIDTH{1'b0}}};
      sel = hi2 ? sum[P-1:WIDTH] : sum[WIDTH-1:0];
   end

   // stage 3 register: full product, selected word and validity
   always_ff @(posedge clk) begin
      if (reset) begin
         p3 <= '0;
         r3 <= '0;
         v3 <= 1'b0;
      end else if (en) begin
         p3 <= sum;
         r3 <= sel;
         v3 <= v2;
      end
   end

   generate
      if (REG_OUT != 0) begin : g_out_reg
         logic [P-1:0]     p4;
         logic [WIDTH-1:0] r4;
         logic             v4;

         // optional output stage for timing closure, one extra cycle of latency
         always_ff @(posedge clk) begin
            if (reset) begin
               p4 <= '0;
               r4 <= '0;
               v4 <= 1'b0;
            end else if (en) begin
               p4 <= p3;
               r4 <= r3;
               v4 <= v3;
            end
         end

         assign out_valid = v4;
         assign result    = r4;
         assign prod      = p4;
      end else begin : g_no_out_reg
         assign out_valid = v3;
         assign result    = r3;
         assign prod      = p3;
      end
   endgenerate

endmodule

// File: tb/tb_nios2_mul_pipe.sv
// tb/tb_nios2_mul_pipe.sv - scoreboard bench for nios2_mul_pipe at WIDTH=32, WIDTH=16 and REG_OUT=1
module tb_nios2_mul_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, en, in_valid, s1s, s2s, hi_sel;
   logic [31:0] src1, src2;

   logic        ov32, ovr, ov16;
   logic [31:0] res32, resr;
   logic [15:0] res16;
   logic [63:0] prod32, prodr;
   logic [31:0] prod16;

   typedef struct packed {
      logic [63:0] p;
      logic [31:0] r;
   } exp_t;

   exp_t q32[$];
   exp_t qr[$];
   exp_t q16[$];

   int n_checks = 0;
   int n_fail   = 0;

   nios2_mul_pipe #(.WIDTH(32), .REG_OUT(0)) dut32 (
      .clk(clk), .reset(reset), .en(en), .in_valid(in_valid),
      .src1(src1), .src2(src2), .src1_signed(s1s), .src2_signed(s2s), .hi_sel(hi_sel),
      .out_valid(ov32), .result(res32), .prod(prod32));

   nios2_mul_pipe #(.WIDTH(32), .REG_OUT(1)) dutr (
      .clk(clk), .reset(reset), .en(en), .in_valid(in_valid),
      .src1(src1), .src2(src2), .src1_signed(s1s), .src2_signed(s2s), .hi_sel(hi_sel),
      .out_valid(ovr), .result(resr), .prod(prodr));

   nios2_mul_pipe #(.WIDTH(16), .REG_OUT(0)) dut16 (
      .clk(clk), .reset(reset), .en(en), .in_valid(in_valid),
      .src1(src1[15:0]), .src2(src2[15:0]), .src1_signed(s1s), .src2_signed(s2s), .hi_sel(hi_sel),
      .out_valid(ov16), .result(res16), .prod(prod16));

   // reference: extend each operand per its flag, multiply, keep 2*WIDTH bits
   function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b,
                                         input logic sa, input logic sb);
      logic [63:0] x, y;
      x = {{32{sa & a[31]}}, a};
      y = {{32{sb & b[31]}}, b};
      return x * y;
   endfunction

   function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b,
                                         input logic sa, input logic sb);
      logic [31:0] x, y;
      x = {{16{sa & a[15]}}, a};
      y = {{16{sb & b[15]}}, b};
      return x * y;
   endfunction

   function automatic void push_exp();
      exp_t        e;
      logic [63:0] p;
      logic [31:0] p16;
      p   = ref32(src1, src2, s1s, s2s);
      e.p = p;
      e.r = hi_sel ? p[63:32] : p[31:0];
      q32.push_back(e);
      qr.push_back(e);
      p16 = ref16(src1[15:0], src2[15:0], s1s, s2s);
      e.p = {32'd0, p16};
      e.r = {16'd0, (hi_sel ? p16[31:16] : p16[15:0])};
      q16.push_back(e);
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_8000;
         3: return 32'h7FFF_7FFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic do_reset();
      reset    = 1'b1;
      en       = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      q32.delete();
      qr.delete();
      q16.delete();
   endtask

   // issue one op on dut32 and count negedges until its out_valid rises
   task automatic issue(input logic [31:0] a, input logic [31:0] b,
                        input logic sa, input logic sb, input logic hi, output int lat);
      src1 = a; src2 = b; s1s = sa; s2s = sb; hi_sel = hi;
      en = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!ov32 && lat < 10) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      int lat, seen;
      reset = 1'b1; en = 1'b0; in_valid = 1'b0;
      src1 = 32'd5; src2 = 32'd6; s1s = 1'b0; s2s = 1'b0; hi_sel = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_checks++; if (ov32 !== 1'b0)   begin n_fail++; $display("FAIL reset_ov32: got %b expected 0", ov32); end
      n_checks++; if (res32 !== 32'd0) begin n_fail++; $display("FAIL reset_res32: got %h expected 0", res32); end
      n_checks++; if (prod32 !== 64'd0) begin n_fail++; $display("FAIL reset_prod32: got %h expected 0", prod32); end
      n_checks++; if (ovr !== 1'b0 || prodr !== 64'd0) begin n_fail++; $display("FAIL reset_regout: got ov=%b prod=%h expected 0/0", ovr, prodr); end
      n_checks++; if (ov16 !== 1'b0 || prod16 !== 32'd0) begin n_fail++; $display("FAIL reset_w16: got ov=%b prod=%h expected 0/0", ov16, prod16); end

      // reset coincident with en and in_valid drops the op
      en = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      reset = 1'b0; in_valid = 1'b0;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (ov32) seen++;
      end
      n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL reset_drops_op: got %0d valids expected 0", seen); end

      // releasing reset with in_valid high accepts the op on that edge
      reset = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!ov32 && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL reset_release_latency: got %0d expected 3", lat); end
      n_checks++; if (prod32 !== 64'd30 || res32 !== 32'd30) begin n_fail++; $display("FAIL reset_release_value: got %h/%h expected 30/30", prod32, res32); end
   endtask

   task automatic test_unsigned();
      int lat;
      do_reset();
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, lat);
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL uu_latency: got %0d expected 3", lat); end
      n_checks++; if (prod32 !== 64'hFFFF_FFFE_0000_0001) begin n_fail++; $display("FAIL uu_prod: got %h expected fffffffe00000001", prod32); end
      n_checks++; if (res32 !== 32'h0000_0001) begin n_fail++; $display("FAIL uu_lo: got %h expected 00000001", res32); end
      n_checks++; if (ov16 !== 1'b1 || prod16 !== 32'hFFFE_0001) begin n_fail++; $display("FAIL uu_w16: got ov=%b prod=%h expected 1/fffe0001", ov16, prod16); end
      @(negedge clk);
      n_checks++; if (ovr !== 1'b1 || prodr !== 64'hFFFF_FFFE_0000_0001) begin n_fail++; $display("FAIL uu_regout_lat4: got ov=%b prod=%h expected 1/fffffffe00000001", ovr, prodr); end
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, lat);
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL uu_hi_latency: got %0d expected 3", lat); end
      n_checks++; if (res32 !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL uu_hi: got %h expected fffffffe", res32); end
   endtask

   task automatic test_signed();
      int lat;
      do_reset();
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, lat);
      n_checks++; if (prod32 !== 64'd1) begin n_fail++; $display("FAIL ss_m1: got %h expected 1", prod32); end
      issue(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b1, lat);
      n_checks++; if (prod32 !== 64'h4000_0000_0000_0000) begin n_fail++; $display("FAIL ss_min_prod: got %h expected 4000000000000000", prod32); end
      n_checks++; if (res32 !== 32'h4000_0000) begin n_fail++; $display("FAIL ss_min_hi: got %h expected 40000000", res32); end
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, lat);
      n_checks++; if (res32 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL su_hi: got %h expected ffffffff", res32); end
      n_checks++; if (prod32 !== 64'hFFFF_FFFF_0000_0001) begin n_fail++; $display("FAIL su_prod: got %h expected ffffffff00000001", prod32); end
   endtask

   task automatic test_stall();
      logic [31:0] a[5];
      logic [31:0] b[5];
      int   issued, got;
      exp_t e, last;
      a = '{32'd3, 32'd2, 32'hFFFF_FFFB, 32'd100, 32'h1234_5678};
      b = '{32'd7, 32'hFFFF_FFFC, 32'hFFFF_FFFA, 32'd200, 32'hFFFF_FFFF};
      issued = 0; got = 0; last = '0;
      do_reset();
      for (int c = 0; c < 12; c++) begin
         en = !(c >= 3 && c <= 6);
         in_valid = en && (issued < 5);
         if (in_valid) begin
            src1 = a[issued]; src2 = b[issued];
            s1s = 1'b1; s2s = 1'b1; hi_sel = issued[0];
            push_exp();
            issued++;
         end
         @(negedge clk);
         if (en) begin
            if (ov32) begin
               n_checks++;
               if (q32.size() == 0) begin
                  n_fail++; $display("FAIL stall_extra_output: got prod %h expected none", prod32);
               end else begin
                  e = q32.pop_front();
                  last = e;
                  got++;
                  if (prod32 !== e.p || res32 !== e.r) begin
                     n_fail++; $display("FAIL stall_order: got %h/%h expected %h/%h", prod32, res32, e.p, e.r);
                  end
               end
            end
         end else begin
            n_checks++;
            if (ov32 !== 1'b1 || prod32 !== last.p || res32 !== last.r) begin
               n_fail++; $display("FAIL stall_hold: got %b/%h/%h expected 1/%h/%h", ov32, prod32, res32, last.p, last.r);
            end
         end
      end
      n_checks++; if (got !== 5) begin n_fail++; $display("FAIL stall_count: got %0d expected 5", got); end
      n_checks++; if (q32.size() !== 0) begin n_fail++; $display("FAIL stall_lost: got %0d pending expected 0", q32.size()); end
   endtask

   task automatic test_reset_midflight();
      int lat, seen;
      do_reset();
      en = 1'b1; s1s = 1'b0; s2s = 1'b0; hi_sel = 1'b0;
      for (int i = 0; i < 3; i++) begin
         src1 = 32'(i + 1); src2 = 32'd10; in_valid = 1'b1;
         @(negedge clk);
      end
      reset = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      n_checks++; if (ov32 !== 1'b0 || res32 !== 32'd0 || prod32 !== 64'd0) begin n_fail++; $display("FAIL midflight_clear: got %b/%h/%h expected 0/0/0", ov32, res32, prod32); end
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ov32 || ovr || ov16) seen++;
      end
      n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midflight_stale: got %0d valids expected 0", seen); end
      issue(32'd9, 32'd9, 1'b0, 1'b0, 1'b0, lat);
      n_checks++; if (lat !== 3 || res32 !== 32'd81) begin n_fail++; $display("FAIL midflight_new_op: got lat %0d res %h expected 3/51", lat, res32); end
   endtask

   task automatic test_random();
      int   issued, drain, c;
      exp_t e;
      issued = 0; drain = 0; c = 0;
      do_reset();
      while (drain < 6 && c < 40000) begin
         if (issued < 10000) begin
            en       = ($urandom_range(0, 4) != 0);
            in_valid = ($urandom_range(0, 4) != 0);
         end else begin
            en = 1'b1; in_valid = 1'b0; drain++;
         end
         src1 = pick(); src2 = pick();
         s1s = 1'($urandom_range(0, 1)); s2s = 1'($urandom_range(0, 1));
         hi_sel = 1'($urandom_range(0, 1));
         if (en && in_valid) begin
            push_exp();
            issued++;
         end
         @(negedge clk);
         c++;
         if (en) begin
            if (ov32) begin
               n_checks++;
               if (q32.size() == 0) begin n_fail++; $display("FAIL rnd32_extra: got %h expected none", prod32); end
               else begin
                  e = q32.pop_front();
                  if (prod32 !== e.p || res32 !== e.r) begin n_fail++; $display("FAIL rnd32: got %h/%h expected %h/%h", prod32, res32, e.p, e.r); end
               end
            end else begin
               n_checks++;
               if ($isunknown(prod32) || $isunknown(res32)) begin n_fail++; $display("FAIL rnd32_bubble_x: got %h/%h expected known", prod32, res32); end
            end
            if (ovr) begin
               n_checks++;
               if (qr.size() == 0) begin n_fail++; $display("FAIL rndreg_extra: got %h expected none", prodr); end
               else begin
                  e = qr.pop_front();
                  if (prodr !== e.p || resr !== e.r) begin n_fail++; $display("FAIL rndreg: got %h/%h expected %h/%h", prodr, resr, e.p, e.r); end
               end
            end
            if (ov16) begin
               n_checks++;
               if (q16.size() == 0) begin n_fail++; $display("FAIL rnd16_extra: got %h expected none", prod16); end
               else begin
                  e = q16.pop_front();
                  if (prod16 !== e.p[31:0] || res16 !== e.r[15:0]) begin n_fail++; $display("FAIL rnd16: got %h/%h expected %h/%h", prod16, res16, e.p[31:0], e.r[15:0]); end
               end
            end
         end
      end
      n_checks++; if (issued !== 10000) begin n_fail++; $display("FAIL rnd_budget: got %0d issued expected 10000", issued); end
      n_checks++; if (q32.size() !== 0) begin n_fail++; $display("FAIL rnd32_lost: got %0d pending expected 0", q32.size()); end
      n_checks++; if (qr.size() !== 0) begin n_fail++; $display("FAIL rndreg_lost: got %0d pending expected 0", qr.size()); end
      n_checks++; if (q16.size() !== 0) begin n_fail++; $display("FAIL rnd16_lost: got %0d pending expected 0", q16.size()); end
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; in_valid = 1'b0;
      src1 = '0; src2 = '0; s1s = 1'b0; s2s = 1'b0; hi_sel = 1'b0;
      @(negedge clk);
      test_reset();
      test_unsigned();
      test_signed();
      test_stall();
      test_reset_midflight();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/nios2_mul_pipe.md
Name: nios2_mul_pipe

Overview:
- Parametrised pipelined integer multiplier for the Nios II execute/memory path.
- Successor to the fixed 16x16 three-partial-product multiplier cell.
- Splits operands into halves, forms all four partial products (including hi x hi) and sums them into the full 2*WIDTH product.
- Supports mul/mulxss/mulxsu/mulxuu semantics through per-operand signedness and a high/low word select, with valid tracking and pipeline stall.

Parameters:
- WIDTH, 32: operand width; must be even and >= 8; each half is WIDTH/2 bits.
- REG_OUT, 0: 1 adds an output register stage; latency becomes 4 instead of 3.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  pipeline advance enable; 0 freezes every stage (stall).
- in_valid  in  1  src1/src2/mode are valid this cycle; sampled only when en=1.
- src1  in  WIDTH  multiplicand.
- src2  in  WIDTH  multiplier.
- src1_signed  in  1  1 means src1 is two's complement.
- src2_signed  in  1  1 means src2 is two's complement.
- hi_sel  in  1  1 selects the upper WIDTH bits of the product for result; 0 selects the lower.
- out_valid  out  1  result/prod valid.
- result  out  WIDTH  selected product word.
- prod  out  2*WIDTH  full product.

Behaviour:
- Reset (synchronous, reset=1 at a clk edge):
  - All valid bits, operand registers and partial-product registers clear to 0.
  - out_valid=0, result=0, prod=0 from the following cycle.
  - Reset overrides en; any in-flight operations are discarded.
- Pipeline, REG_OUT=0 (stage advances only when en=1):
  - S1: register src1, src2, both signed flags, hi_sel, in_valid.
  - S2: register four unsigned (WIDTH/2)x(WIDTH/2) partial products: ll=a_lo*b_lo, lh=a_lo*b_hi, hl=a_hi*b_lo, hh=a_hi*b_hi. Also register the sign-correction terms: corrA = a_msb&src1_signed ? b : 0, and corrB = b_msb&src2_signed ? a : 0.
  - S3: prod = ll + (lh<<H) + (hl<<H) + (hh<<2H) - (corrA<<WIDTH) - (corrB<<WIDTH), computed modulo 2^(2*WIDTH), where H = WIDTH/2. result = hi_sel ? prod[2W-1:W] : prod[W-1:0]. out_valid = stage-2 valid.
- Pipeline, REG_OUT=1: an extra register stage holds prod, result and out_valid.
- Latency: out_valid rises exactly 3 (or 4) en=1 cycles after in_valid is sampled. Cycles with en=0 do not count.
- Arithmetic rule: prod equals the exact mathematical product of the operands, each interpreted per its signed flag, truncated to 2*WIDTH bits. For signed x signed this is exact with no overflow.
- Stall: while en=0, all registers hold their value, including out_valid and result. No duplicate or lost operations.
- Throughput: one operation per en=1 cycle; back-to-back inputs produce back-to-back outputs.
- Bubbles: in_valid=0 with en=1 propagates a bubble. out_valid=0 for that slot; result and prod still update (don't-care content, no X allowed).
- Boundary cases:
  - Mode flags and hi_sel are captured with their operands. Changing them mid-flight does not affect earlier operations.
  - reset asserted together with en and in_valid: reset wins, and the operation is dropped.
  - Deasserting reset with en=1 and in_valid=1 in that same cycle: the operation is accepted on the next edge.
  - WIDTH=8: halves are 4 bits; the same equations apply.

Test Plan:
- Unsigned, WIDTH=32, src1=src2=0xFFFFFFFF, hi_sel=0 then 1 -> prod=0xFFFFFFFE00000001; results 0x00000001 then 0xFFFFFFFE, three cycles after each issue.
- Signed x signed: src1=src2=0xFFFFFFFF -> prod=0x0000000000000001. src1=src2=0x80000000 -> prod=0x4000000000000000, result(hi)=0x40000000.
- Signed x unsigned: src1=0xFFFFFFFF (signed), src2=0xFFFFFFFF (unsigned), hi_sel=1 -> result=0xFFFFFFFF, prod=0xFFFFFFFF00000001.
- Stall: issue 5 back-to-back ops (3*7, 2*-4, ...), drop en for 4 cycles mid-stream -> outputs hold steady during the stall. All 5 results then appear in order; out_valid counts 5, with total cycles = 5 + 3 + 4.
- Reset mid-flight: 3 ops in flight, assert reset for 1 cycle -> out_valid=0 and result=0 the next cycle; no stale result ever emerges. A new op after reset completes with 3-cycle latency.
- Randomised 10k ops in all four sign modes with random en and in_valid, run at WIDTH=32, WIDTH=16 and REG_OUT=1 -> prod matches the reference model every out_valid cycle.
